pll_reconfig_ctrl: RTL

Runtime PLL reconfiguration controller for the HDMI clocking path. It replaces the fixed single-mode PLL setup with a table of NUM_MODES divider sets, for example 480p and 720p. It drives the PLL dynamic-programming port, PLL reset and the downstream video reset, and it supervises lock with a timeout, retries and loss-of-lock recovery. It sits between the display-mode register and the PLL primitive wrapper.

---
 rtl/pll_reconfig_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// Runtime PLL reconfiguration controller: programs one of NUM_MODES divider sets through
// the PLL dynamic-programming port, then supervises lock with timeout, retries and recovery.
module pll_reconfig_ctrl #(
    parameter int                        NUM_MODES    = 2,
    parameter logic [NUM_MODES*32-1:0]   MODE_CFG     = {32'h04_3D_01_02, 32'h04_3D_01_02},
    parameter int                        DEFAULT_MODE = 0,
    parameter int                        RST_CYCLES   = 16,
    parameter int                        LOCK_TIMEOUT = 65535,
    parameter int                        LOCK_STABLE  = 1024,
    parameter int                        MAX_RETRIES  = 3,
    localparam int                       MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [MW-1:0] mode_sel,
    input  logic          req,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [MW-1:0] cur_mode,
    input  logic          pll_lock,
    output logic          pll_reset,
    output logic [1:0]    md_opc,
    output logic          md_ainc,
    output logic [7:0]    md_wdi,
    output logic          video_rst_n
);

    localparam int RCW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int TOW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int STW = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)   : 1;
    localparam int RTW = (MAX_RETRIES  > 0) ? $clog2(MAX_RETRIES+1) : 1;

    localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
    localparam logic [TOW-1:0] TOUT_LAST   = TOW'(LOCK_TIMEOUT - 1);
    localparam logic [STW-1:0] STABLE_LAST = STW'(LOCK_STABLE - 1);
    localparam logic [RTW-1:0] RETRY_MAX   = RTW'(MAX_RETRIES);
    localparam logic [MW:0]    MODES_X     = (MW+1)'(NUM_MODES);
    localparam logic [MW-1:0]  DEF_MODE    = MW'(DEFAULT_MODE);
    localparam logic [1:0]     OPC_WR      = 2'b01;

    typedef enum logic [2:0] {
        S_RST, S_PROG, S_RELEASE, S_WAIT, S_IDLE, S_FAIL
    } state_t;

    state_t         state_q;
    logic [RCW-1:0] rst_cnt_q;
    logic [2:0]     prog_idx_q;
    logic [STW-1:0] stable_q;
    logic [TOW-1:0] tout_q;
    logic [RTW-1:0] retry_q;
    logic [MW-1:0]  tgt_q;
    logic [MW-1:0]  cur_mode_q;
    logic           pll_reset_q;
    logic           video_rst_n_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;
    logic [1:0]     md_opc_q;
    logic           md_ainc_q;
    logic [7:0]     md_wdi_q;

    logic           sel_valid;
    logic           start_d;

    function automatic logic [7:0] cfg_byte(input logic [MW-1:0] m, input logic [1:0] k);
        return MODE_CFG[{m, k, 3'b000} +: 8];
    endfunction

    // Only IDLE and FAIL accept requests; anything arriving while busy is dropped.
    assign sel_valid = {1'b0, mode_sel} < MODES_X;
    assign start_d   = req && sel_valid && (state_q == S_IDLE || state_q == S_FAIL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_RST;
            rst_cnt_q     <= '0;
            prog_idx_q    <= '0;
            stable_q      <= '0;
            tout_q        <= '0;
            retry_q       <= '0;
            tgt_q         <= DEF_MODE;
            cur_mode_q    <= DEF_MODE;
            pll_reset_q   <= 1'b1;
            video_rst_n_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            md_opc_q      <= 2'b00;
            md_ainc_q     <= 1'b0;
            md_wdi_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            md_opc_q  <= 2'b00;
            md_ainc_q <= 1'b0;
            md_wdi_q  <= '0;
            if (start_d) begin
                tgt_q         <= mode_sel;
                state_q       <= S_RST;
                rst_cnt_q     <= '0;
                retry_q       <= '0;
                pll_reset_q   <= 1'b1;
                video_rst_n_q <= 1'b0;
                busy_q        <= 1'b1;
            end else begin
                case (state_q)
                    S_RST: begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q    <= S_PROG;
                            prog_idx_q <= '0;
                            md_opc_q   <= OPC_WR;
                            md_wdi_q   <= cfg_byte(tgt_q, 2'd0);
                        end else begin
                            rst_cnt_q <= rst_cnt_q + 1'b1;
                        end
                    end
                    // Even index = write cycle, odd index = address increment.
                    S_PROG: begin
                        if (prog_idx_q == 3'd7) begin
                            state_q     <= S_RELEASE;
                            pll_reset_q <= 1'b0;
                        end else begin
                            prog_idx_q <= prog_idx_q + 1'b1;
                            if (prog_idx_q[0]) begin
                                md_opc_q <= OPC_WR;
                                md_wdi_q <= cfg_byte(tgt_q, prog_idx_q[2:1] + 2'd1);
                            end else begin
                                md_ainc_q <= 1'b1;
                            end
                        end
                    end
                    S_RELEASE: begin
                        state_q  <= S_WAIT;
                        stable_q <= '0;
                        tout_q   <= '0;
                    end
                    S_WAIT: begin
                        if (pll_lock && stable_q == STABLE_LAST) begin
                            state_q       <= S_IDLE;
                            video_rst_n_q <= 1'b1;
                            done_q        <= 1'b1;
                            busy_q        <= 1'b0;
                            cur_mode_q    <= tgt_q;
                            retry_q       <= '0;
                        end else begin
                            stable_q <= pll_lock ? stable_q + 1'b1 : '0;
                            if (tout_q == TOUT_LAST) begin
                                pll_reset_q <= 1'b1;
                                if (retry_q < RETRY_MAX) begin
                                    retry_q   <= retry_q + 1'b1;
                                    state_q   <= S_RST;
                                    rst_cnt_q <= '0;
                                end else begin
                                    state_q <= S_FAIL;
                                    busy_q  <= 1'b0;
                                    err_q   <= 1'b1;
                                end
                            end else begin
                                tout_q <= tout_q + 1'b1;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (req && !sel_valid) begin
                            err_q <= 1'b1;
                        end
                        // Loss of lock: re-supervise the existing setting, no reprogramming.
                        if (!pll_lock) begin
                            state_q       <= S_WAIT;
                            video_rst_n_q <= 1'b0;
                            busy_q        <= 1'b1;
                            stable_q      <= '0;
                            tout_q        <= '0;
                            retry_q       <= '0;
                        end
                    end
                    S_FAIL: begin
                        err_q <= 1'b1;
                    end
                    default: begin
                        state_q <= S_RST;
                    end
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cur_mode    = cur_mode_q;
    assign pll_reset   = pll_reset_q;
    assign md_opc      = md_opc_q;
    assign md_ainc     = md_ainc_q;
    assign md_wdi      = md_wdi_q;
    assign video_rst_n = video_rst_n_q;

endmodule
